// File: rtl/operand_load_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : operand_load_scheduler
//  Description : Controller for the split-word operand datapath. It loads
//                NUM_OPS operands from a shared byte bus, one high byte and
//                then one low byte per operand. It then runs a fixed-length
//                execute phase and presents the result with a valid/ready
//                handshake.
//  Ports       : CLK, RESET (async, active-low)
//                in_valid / in_ready    - byte input bus handshake
//                en_high / en_low       - operand half load enables
//                op_sel                 - operand register index being loaded
//                exec_en / exec_first   - compute enable / first compute cycle
//                out_valid / out_ready  - result handshake
//                abort                  - synchronous transaction abort
//                busy                   - transaction in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_load_scheduler #(
    parameter  int NUM_OPS     = 2,
    parameter  int EXEC_CYCLES = 4,
    localparam int OPW         = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           en_high,
    output logic           en_low,
    output logic [OPW-1:0] op_sel,
    output logic           exec_en,
    output logic           exec_first,
    output logic           out_valid,
    input  logic           out_ready,
    input  logic           abort,
    output logic           busy
);

    localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    localparam logic [OPW-1:0] c_OP_LAST  = OPW'(NUM_OPS - 1);
    localparam logic [CW-1:0]  c_CNT_LAST = CW'(EXEC_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_HI = 3'd1,
        S_LOAD_LO = 3'd2,
        S_EXEC    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [OPW-1:0] r_op_sel;
    logic [OPW-1:0] w_op_sel_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state  <= S_IDLE;
            r_op_sel <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_op_sel <= w_op_sel_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // op_sel comes straight from the register so it stays constant over a
    // HI/LO pair; the register is cleared whenever loading ends.
    assign op_sel = r_op_sel;
    assign busy   = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt  = r_state;
        w_op_sel_nxt = r_op_sel;
        w_cnt_nxt    = r_cnt;
        in_ready     = 1'b0;
        en_high      = 1'b0;
        en_low       = 1'b0;
        exec_en      = 1'b0;
        exec_first   = 1'b0;
        out_valid    = 1'b0;

        // Abort wins over every transfer and handshake in the same cycle and
        // keeps all strobes low so nothing downstream acts on this cycle.
        if (abort) begin
            w_state_nxt  = S_IDLE;
            w_op_sel_nxt = '0;
            w_cnt_nxt    = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A pending byte only wakes the sequencer; it is consumed
                    // in LOAD_HI on the following cycle.
                    if (in_valid) begin
                        w_state_nxt = S_LOAD_HI;
                    end
                end
                S_LOAD_HI: begin
                    in_ready = 1'b1;
                    en_high  = in_valid;
                    if (in_valid) begin
                        w_state_nxt = S_LOAD_LO;
                    end
                end
                S_LOAD_LO: begin
                    in_ready = 1'b1;
                    en_low   = in_valid;
                    if (in_valid) begin
                        if (r_op_sel == c_OP_LAST) begin
                            w_state_nxt  = S_EXEC;
                            w_op_sel_nxt = '0;
                            w_cnt_nxt    = '0;
                        end else begin
                            w_state_nxt  = S_LOAD_HI;
                            w_op_sel_nxt = r_op_sel + OPW'(1);
                        end
                    end
                end
                S_EXEC: begin
                    exec_en    = 1'b1;
                    exec_first = (r_cnt == '0);
                    if (r_cnt == c_CNT_LAST) begin
                        // Counter is parked at zero on exit so it never wraps.
                        w_state_nxt = S_DONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_op_sel_nxt = '0;
                    w_cnt_nxt    = '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
